coin_report_framer: RTL and testbench

//  Builds the coin-count report frame sent over the UART after any coin counter changes.

---
 rtl/coin_report_framer.sv | 142 ++++++++++++++
 tb/tb_coin_report_framer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_report_framer.sv
// Snapshots four 3-digit ASCII coin counts and streams them as a fixed report frame
// over a valid/ready byte interface, with optional CR/LF and inter-frame gap.
module coin_report_framer #(
    parameter int unsigned GAP_CYCLES = 0,
    parameter bit          SEND_CRLF  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_sending,
    input  logic [23:0] tenbaht,
    input  logic [23:0] fivebaht,
    input  logic [23:0] twobaht,
    input  logic [23:0] onebaht,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        frame_done
);

    localparam logic [4:0] LastIdx = SEND_CRLF ? 5'd20 : 5'd18;
    localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

    typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

    state_e          state_q, state_d;
    logic [95:0]     snap_q, snap_d;
    logic [4:0]      idx_q, idx_d;
    logic [GapW-1:0] gap_q, gap_d;
    logic            pending_q, pending_d;
    logic            done_q, done_d;
    logic [7:0]      cur_byte;
    logic            req;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            snap_q    <= '0;
            idx_q     <= '0;
            gap_q     <= '0;
            pending_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            snap_q    <= snap_d;
            idx_q     <= idx_d;
            gap_q     <= gap_d;
            pending_q <= pending_d;
            done_q    <= done_d;
        end
    end

    // Snapshot layout: ten in [95:72], five in [71:48], two in [47:24], one in [23:0].
    always_comb begin
        cur_byte = 8'h00;
        unique case (idx_q)
            5'd0:    cur_byte = 8'h54;
            5'd1:    cur_byte = snap_q[95:88];
            5'd2:    cur_byte = snap_q[87:80];
            5'd3:    cur_byte = snap_q[79:72];
            5'd4:    cur_byte = 8'h20;
            5'd5:    cur_byte = 8'h46;
            5'd6:    cur_byte = snap_q[71:64];
            5'd7:    cur_byte = snap_q[63:56];
            5'd8:    cur_byte = snap_q[55:48];
            5'd9:    cur_byte = 8'h20;
            5'd10:   cur_byte = 8'h57;
            5'd11:   cur_byte = snap_q[47:40];
            5'd12:   cur_byte = snap_q[39:32];
            5'd13:   cur_byte = snap_q[31:24];
            5'd14:   cur_byte = 8'h20;
            5'd15:   cur_byte = 8'h4F;
            5'd16:   cur_byte = snap_q[23:16];
            5'd17:   cur_byte = snap_q[15:8];
            5'd18:   cur_byte = snap_q[7:0];
            5'd19:   cur_byte = 8'h0D;
            5'd20:   cur_byte = 8'h0A;
            default: cur_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        snap_d    = snap_q;
        idx_d     = idx_q;
        gap_d     = gap_q;
        pending_d = pending_q;
        done_d    = 1'b0;
        req       = start_sending | pending_q;

        unique case (state_q)
            StIdle: begin
                if (req) begin
                    snap_d    = {tenbaht, fivebaht, twobaht, onebaht};
                    pending_d = 1'b0;
                    idx_d     = 5'd0;
                    state_d   = StSend;
                end
            end
            StSend: begin
                if (start_sending) pending_d = 1'b1;
                if (tx_ready) begin
                    if (idx_q == LastIdx) begin
                        done_d = 1'b1;
                        if (GAP_CYCLES > 0) begin
                            state_d = StGap;
                            gap_d   = GapW'(GAP_CYCLES);
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            StGap: begin
                if (start_sending) pending_d = 1'b1;
                // Leaving the gap is the IDLE entry edge: a waiting request snapshots here,
                // so exactly GAP_CYCLES non-valid cycles separate back-to-back frames.
                if (gap_q <= GapW'(1)) begin
                    if (req) begin
                        snap_d    = {tenbaht, fivebaht, twobaht, onebaht};
                        pending_d = 1'b0;
                        idx_d     = 5'd0;
                        state_d   = StSend;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    gap_d = gap_q - GapW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign tx_valid   = (state_q == StSend);
    assign tx_data    = (state_q == StSend) ? cur_byte : 8'h00;
    assign busy       = (state_q != StIdle);
    assign frame_done = done_q;

endmodule

// File: tb/tb_coin_report_framer.sv
// Scoreboard bench for coin_report_framer: a reference frame builder queues expected bytes,
// a negedge monitor pops and compares every transfer, hold stability and frame_done.
module tb_coin_report_framer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_sending = 1'b0;
    logic [23:0] tenbaht, fivebaht, twobaht, onebaht;
    logic        tx_ready = 1'b1;
    logic [7:0]  tx_data;
    logic        tx_valid, busy, frame_done;

    logic        start1 = 1'b0;
    logic        tx_ready1 = 1'b1;
    logic [7:0]  tx_data1;
    logic        tx_valid1, busy1, frame_done1;

    always #5 clk = ~clk;

    coin_report_framer u_dut (
        .clk          (clk),
        .rst          (rst),
        .start_sending(start_sending),
        .tenbaht      (tenbaht),
        .fivebaht     (fivebaht),
        .twobaht      (twobaht),
        .onebaht      (onebaht),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    coin_report_framer #(
        .GAP_CYCLES(4),
        .SEND_CRLF (1'b0)
    ) u_dut_gap (
        .clk          (clk),
        .rst          (rst),
        .start_sending(start1),
        .tenbaht      (tenbaht),
        .fivebaht     (fivebaht),
        .twobaht      (twobaht),
        .onebaht      (onebaht),
        .tx_data      (tx_data1),
        .tx_valid     (tx_valid1),
        .tx_ready     (tx_ready1),
        .busy         (busy1),
        .frame_done   (frame_done1)
    );

    typedef struct {
        logic [7:0] b;
        bit         last;
        int         idx;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    int   xfer_cnt = 0;
    bit   rand_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        checks++;
        $display("FAIL %s: condition not met", name);
    endtask

    // Reference frame: groups of five (letter, three digits, space), then optional CR LF.
    function automatic logic [7:0] frame_byte(input int i, input logic [95:0] f);
        logic [31:0] letters;
        int grp;
        int pos;
        letters = "TFWO";
        if (i == 19) return 8'h0D;
        if (i == 20) return 8'h0A;
        grp = i / 5;
        pos = i % 5;
        if (pos == 0) return letters[31 - 8*grp -: 8];
        if (pos == 4) return 8'h20;
        return f[95 - 24*grp - 8*(pos-1) -: 8];
    endfunction

    task automatic push_frame(input logic [95:0] f, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.b = frame_byte(i, f);
            e.last = (i == n - 1);
            e.idx = i;
            exp_q.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_xfers(input int n);
        int k;
        k = 0;
        while (xfer_cnt < n && k < 2000) begin
            tick();
            k++;
        end
        if (xfer_cnt < n) fail_now("wait_xfers_timeout");
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || busy) && k < 3000) begin
            tick();
            k++;
        end
        check("drain_remaining", exp_q.size(), 0);
        check("idle_busy", busy, 1'b0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: every transfer is compared against the scoreboard head.
    bit         prev_hold = 1'b0;
    bit         prev_last = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_hold = 1'b0;
            prev_last = 1'b0;
        end else begin
            if (prev_last) check("frame_done", frame_done, 1'b1);
            else if (frame_done) check("frame_done_spurious", frame_done, 1'b0);
            if (prev_hold) begin
                check("hold_valid", tx_valid, 1'b1);
                check("hold_data", tx_data, prev_data);
            end
            prev_last = 1'b0;
            if (tx_valid && tx_ready) begin
                xfer_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_byte: got %0h, expected no transfer", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("byte%0d", e.idx), tx_data, e.b);
                    prev_last = e.last;
                end
            end
            prev_hold = tx_valid && !tx_ready;
            prev_data = tx_data;
        end
    end

    initial begin
        int k;
        int base;
        int nvalid;
        int phase;
        int idx;
        int gap;
        logic [95:0] snap;

        tenbaht  = "012";
        fivebaht = "005";
        twobaht  = "000";
        onebaht  = "100";

        repeat (3) tick();
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        rst = 1'b0;
        tick();

        // Single frame, back-to-back bytes, frame_done latency.
        snap = {tenbaht, fivebaht, twobaht, onebaht};
        push_frame(snap, 21);
        start_sending = 1'b1;
        tick();
        start_sending = 1'b0;
        k = 1;
        while (!frame_done && k < 40) begin
            tick();
            k++;
            if (k == 5) check("mid_busy", busy, 1'b1);
        end
        check("done_latency", k, 22);
        check("done_busy", busy, 1'b0);
        tick();

        // Backpressure, snapshot isolation and coalesced follow-up.
        rand_ready = 1'b1;
        base = xfer_cnt;
        push_frame(snap, 21);
        start_sending = 1'b1;
        tick();
        start_sending = 1'b0;
        wait_xfers(base + 2);
        tenbaht = "999";
        for (int p = 0; p < 3; p++) begin
            tick();
            start_sending = 1'b1;
            tick();
            start_sending = 1'b0;
        end
        check("pend_busy", busy, 1'b1);
        push_frame({tenbaht, fivebaht, twobaht, onebaht}, 21);
        wait_idle();
        base = xfer_cnt;
        repeat (30) tick();
        check("no_third_frame", xfer_cnt, base);
        rand_ready = 1'b0;

        // Reset mid-frame with a pending request.
        base = xfer_cnt;
        push_frame({tenbaht, fivebaht, twobaht, onebaht}, 21);
        start_sending = 1'b1;
        tick();
        start_sending = 1'b0;
        wait_xfers(base + 7);
        start_sending = 1'b1;
        tick();
        start_sending = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        tick();
        rst = 1'b0;
        check("abort_tx_valid", tx_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        nvalid = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (tx_valid || frame_done) nvalid++;
        end
        check("abort_no_activity", nvalid, 0);
        twobaht = "417";
        push_frame({tenbaht, fivebaht, twobaht, onebaht}, 21);
        start_sending = 1'b1;
        tick();
        start_sending = 1'b0;
        wait_idle();

        // Gap instance: 19-byte frames, start held high, count idle cycles between frames.
        snap = {tenbaht, fivebaht, twobaht, onebaht};
        start1 = 1'b1;
        phase = 0;
        idx = 0;
        gap = 0;
        k = 0;
        while (phase < 3 && k < 200) begin
            tick();
            k++;
            case (phase)
                0: if (tx_valid1) begin
                    check("gap_byte0", tx_data1, frame_byte(0, snap));
                    idx = 1;
                    phase = 1;
                end
                1: if (tx_valid1) begin
                    check($sformatf("gap_byte%0d", idx), tx_data1, frame_byte(idx, snap));
                    idx++;
                end else begin
                    check("gap_frame_len", idx, 19);
                    check("gap_frame_done", frame_done1, 1'b1);
                    gap = 1;
                    phase = 2;
                end
                default: if (tx_valid1) begin
                    check("gap_cycles", gap, 4);
                    check("gap_next_first", tx_data1, 8'h54);
                    phase = 3;
                end else begin
                    check("gap_busy", busy1, 1'b1);
                    gap++;
                end
            endcase
        end
        if (phase < 3) fail_now("gap_timeout");
        start1 = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
